// File: rtl/aes_192_ctr_ctrl_if.sv
// Stream, configuration and core-side bundle for the AES-192 CTR sequencer.
// The slave modport is the controller. The master modport is whoever drives
// the configuration and input stream, accepts results and hosts the core.
interface aes_192_ctr_ctrl_if;
  logic         cfg_load;
  logic [191:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         cfg_done;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         err;
  logic         core_start;
  logic [127:0] core_state;
  logic [191:0] core_key;
  logic [127:0] core_out;
  logic         core_out_valid;

  modport slave (
    input  cfg_load, cfg_key, cfg_iv, in_valid, in_data, out_ready,
           core_out, core_out_valid,
    output cfg_done, in_ready, out_valid, out_data, err,
           core_start, core_state, core_key
  );

  modport master (
    output cfg_load, cfg_key, cfg_iv, in_valid, in_data, out_ready,
           core_out, core_out_valid,
    input  cfg_done, in_ready, out_valid, out_data, err,
           core_start, core_state, core_key
  );
endinterface

// File: rtl/aes_192_ctr_ctrl.sv
// AES-192 CTR sequencer. For each block it gives the external core a clean
// start edge, waits for the keystream, and returns data ^ keystream.
// Optional feature macro: AES_CTR_TIMEOUT_EN. When it is defined, a WAIT
// watchdog drops a stuck block and sets the sticky err flag.
module aes_192_ctr_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_192_ctr_ctrl_if.slave  io_bus
);

  if (TIMEOUT_CYCLES < 16) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 16");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_KICK, S_WAIT, S_OUT} state_t;

  state_t       r_state, w_next;
  logic [191:0] r_key;
  logic [127:0] r_ctr, r_din, r_dout;
  logic         r_ovld, r_done;
  logic         w_load, w_in_ready, w_in_fire, w_cap, w_out_fire, w_tmo;

  assign w_load     = (r_state == S_IDLE) && io_bus.cfg_load;
  assign w_in_ready = (r_state == S_IDLE) && r_done && !io_bus.cfg_load;
  assign w_in_fire  = w_in_ready && io_bus.in_valid;
  assign w_cap      = (r_state == S_WAIT) && io_bus.core_out_valid;
  assign w_out_fire = (r_state == S_OUT) && io_bus.out_ready;

`ifdef AES_CTR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] r_wcnt;
  logic          r_err;

  // The last permitted WAIT cycle without keystream aborts the block.
  assign w_tmo = (r_state == S_WAIT) && !io_bus.core_out_valid &&
                 (r_wcnt == CW'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles from 0 on entry. Err is sticky until the next config load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
      if (w_load)     r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end
  assign io_bus.err = r_err;
`else
  assign w_tmo      = 1'b0;
  assign io_bus.err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state. PRIME forces one low cycle of start before KICK raises it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_fire) w_next = S_PRIME;
      S_PRIME: w_next = S_KICK;
      S_KICK:  w_next = S_WAIT;
      S_WAIT:  if (w_cap) w_next = S_OUT;
               else if (w_tmo) w_next = S_IDLE;
      S_OUT:   if (w_out_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: config load, input latch, result capture and counter advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_ctr  <= '0;
      r_din  <= '0;
      r_dout <= '0;
      r_ovld <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_key  <= io_bus.cfg_key;
        r_ctr  <= io_bus.cfg_iv;
        r_done <= 1'b1;
      end
      if (w_in_fire) r_din <= io_bus.in_data;
      if (w_cap) begin
        r_dout <= r_din ^ io_bus.core_out;
        r_ovld <= 1'b1;
      end
      if (w_out_fire) begin
        r_ctr  <= r_ctr + 128'd1;
        r_ovld <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.cfg_done   = r_done;
  assign io_bus.out_valid  = r_ovld;
  assign io_bus.out_data   = r_dout;
  assign io_bus.core_start = (r_state == S_KICK) || (r_state == S_WAIT);
  assign io_bus.core_state = r_ctr;
  assign io_bus.core_key   = r_key;

endmodule

// File: tb/tb_aes_192_ctr_ctrl.sv
// Directed bench for aes_192_ctr_ctrl. It uses a behavioural stand-in core
// with programmable latency. The stand-in can leave out_valid stale after
// start falls, or never answer at all.
module tb_aes_192_ctr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_192_ctr_ctrl_if bus();
  aes_192_ctr_ctrl #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  localparam logic [191:0] K  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] K2 = 192'hdeadbeef00000000111111112222222233333333cafef00d;
  localparam logic [127:0] C  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  int total = 0;
  int bad   = 0;

  // Stand-in core keystream: an arbitrary but easy-to-hand-compute mix.
  function automatic logic [127:0] ks(input logic [127:0] s, input logic [191:0] k);
    return {s[63:0], s[127:64]} ^ k[191:64] ^ C;
  endfunction

  // Stand-in core.
  int           lat   = 3;
  bit           mute  = 1'b0;
  bit           stale = 1'b0;
  int           m_cnt;
  logic         m_cov, m_d1, m_d2, m_d3;
  logic [127:0] m_ks;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_cov <= 1'b0; m_ks <= '0;
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_d3 <= 1'b0;
    end else begin
      m_d1 <= m_cov; m_d2 <= m_d1; m_d3 <= m_d2;
      if (bus.core_start) begin
        m_cnt <= m_cnt + 1;
        if (!mute && m_cnt >= lat - 1) begin
          m_cov <= 1'b1;
          m_ks  <= ks(bus.core_state, bus.core_key);
        end
      end else begin
        m_cnt <= 0;
        m_cov <= 1'b0;
      end
    end
  end
  // In stale mode, out_valid and the old keystream linger for 3 cycles after start drops.
  assign bus.core_out_valid = m_cov | (stale & (m_d1 | m_d2 | m_d3));
  assign bus.core_out       = m_ks;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [191:0] k, input logic [127:0] iv);
    @(negedge clk);
    bus.cfg_load = 1'b1; bus.cfg_key = k; bus.cfg_iv = iv; bus.in_valid = 1'b1;
    #1 chk("ready_masked_by_load", bus.in_ready, 0);
    @(negedge clk);
    bus.cfg_load = 1'b0; bus.in_valid = 1'b0;
    chk("cfg_done", bus.cfg_done, 1);
    chk("cfg_key", bus.core_key, k);
    chk("cfg_iv", bus.core_state, iv);
    chk("cfg_err_clear", bus.err, 0);
    chk("load_beats_valid", bus.out_valid, 0);
  endtask

  // Accept one block. Returns at the KICK-cycle negedge (cycle 2).
  task automatic accept_blk(input logic [127:0] d);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = '0;
    chk("prime_start_low", bus.core_start, 0);
    @(negedge clk);
    chk("kick_start_high", bus.core_start, 1);
  endtask

  // Wait for out_valid from cycle 2 on. Returns at the first OUT-cycle negedge.
  task automatic wait_out(input int l, input bit chk_lat, output logic [127:0] r);
    int c = 2;
    while (!bus.out_valid && c < 300) begin @(negedge clk); c++; end
    if (chk_lat) chk("out_latency", c, 3 + l);
    else         chk("out_seen", bus.out_valid, 1);
    r = bus.out_data;
  endtask

  logic [127:0] r, d, exp_ctr, hold;
  int           n;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_load = 0; bus.cfg_key = '0; bus.cfg_iv = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    repeat (2) @(negedge clk);
    // Reset state.
    chk("rst_cfg_done", bus.cfg_done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_state", bus.core_state, 0);
    chk("rst_core_key", bus.core_key, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_ready_before_cfg", bus.in_ready, 0);

    // Encrypt zero under key 00..17 with iv 0.
    cfg(K, 128'h0);
    accept_blk('0);
    wait_out(lat, 1, r);
    chk("enc_zero", r, 128'hdda87ea78249d9e766a67aabe0007f9e);
    @(negedge clk);
    chk("ctr_after_first", bus.core_state, 1);
    // Decrypt with the same iv and get zeros back.
    cfg(K, 128'h0);
    accept_blk(r);
    wait_out(lat, 1, r);
    chk("dec_roundtrip", r, 0);

    // Counter wrap, latency 1.
    lat = 1;
    cfg(K, {{127{1'b1}}, 1'b0});
    exp_ctr = {{127{1'b1}}, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wrap_ctr", bus.core_state, exp_ctr);
      d = {4{32'h1234_0000 + 32'(i)}};
      accept_blk(d);
      wait_out(lat, 1, r);
      chk("wrap_data", r, d ^ ks(exp_ctr, K));
      exp_ctr = exp_ctr + 128'd1;
    end
    @(negedge clk);
    chk("wrap_final", bus.core_state, 1);

    // Output stall for 10 cycles.
    lat = 4; bus.out_ready = 0;
    d = 128'h00ff00ff_a5a5a5a5_0f0f0f0f_3c3c3c3c;
    accept_blk(d);
    wait_out(lat, 1, hold);
    chk("stall_data", hold, d ^ ks(exp_ctr, K));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_hold", bus.out_data, hold);
      chk("stall_ready", bus.in_ready, 0);
      chk("stall_ctr", bus.core_state, exp_ctr);
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("stall_release", bus.out_valid, 0);
    exp_ctr = exp_ctr + 128'd1;
    chk("stall_ctr_inc", bus.core_state, exp_ctr);

    // Stale core_out_valid through IDLE/PRIME/KICK, back-to-back blocks.
    lat = 2; stale = 1;
    for (int i = 0; i < 3; i++) begin
      d = {4{32'hbeef_0000 ^ 32'(i * 7)}};
      accept_blk(d);
      wait_out(lat, 1, r);
      chk("stale_data", r, d ^ ks(exp_ctr, K));
      exp_ctr = exp_ctr + 128'd1;
    end
    stale = 0;

    // Silent core, with an ignored cfg_load during WAIT.
    lat = 3; mute = 1;
    d = 128'h0badf00d_0badf00d_0badf00d_0badf00d;
    accept_blk(d);
    n = 2;
    while (n < 40 && !(bus.err || bus.out_valid)) begin
      @(negedge clk); n++;
      bus.cfg_load = (n == 7);
      if (n == 7) begin bus.cfg_key = K2; bus.cfg_iv = 128'h55; end
      if (n == 8) begin
        chk("wait_load_key", bus.core_key, K);
        chk("wait_load_ctr", bus.core_state, exp_ctr);
        chk("wait_load_start", bus.core_start, 1);
      end
    end
    bus.cfg_load = 0;
`ifdef AES_CTR_TIMEOUT_EN
    chk("tmo_cycle", n, 19);
    chk("tmo_err", bus.err, 1);
    chk("tmo_no_valid", bus.out_valid, 0);
    chk("tmo_idle", bus.in_ready, 1);
    chk("tmo_ctr_kept", bus.core_state, exp_ctr);
    mute = 0;
    cfg(K, exp_ctr);
`else
    chk("no_tmo_err", bus.err, 0);
    chk("no_tmo_valid", bus.out_valid, 0);
    mute = 0;
    wait_out(lat, 0, r);
    chk("late_data", r, d ^ ks(exp_ctr, K));
    exp_ctr = exp_ctr + 128'd1;
    @(negedge clk);
    chk("late_ctr", bus.core_state, exp_ctr);
`endif

    // Reset in the middle of WAIT.
    lat = 30;
    accept_blk(128'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", bus.cfg_done, 0);
    chk("mid_rst_start", bus.core_start, 0);
    chk("mid_rst_state", bus.core_state, 0);
    chk("mid_rst_key", bus.core_key, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 0);
    chk("post_rst_start", bus.core_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_192_ctr_ctrl.md
# aes_192_ctr_ctrl

Sequencer for an external `aes_192` core running in CTR mode. It holds the 192-bit key and the 128-bit counter block and accepts plaintext/ciphertext blocks over a valid/ready stream. For each block it produces the clean 0→1 `start` edge the core requires, waits for the core's `out_valid`, XORs the keystream with the data and returns the result over a second valid/ready stream. It sits between the bus-side DMA/stream logic and the core, and replaces ad-hoc software sequencing of `start`.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before a block is aborted. Used only with `AES_CTR_TIMEOUT_EN`; minimum 16.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  one-cycle pulse that loads `cfg_key` and `cfg_iv`. Honoured only in IDLE.
- `cfg_key`  in  192  key.
- `cfg_iv`  in  128  initial counter block.
- `cfg_done`  out  1  key and counter are loaded. Reset value 0.
- `in_valid`  in  1  input block present.
- `in_data`  in  128  plaintext or ciphertext block.
- `in_ready`  out  1  input accepted when high together with `in_valid`. Reset value 0.
- `out_valid`  out  1  result block present. Reset value 0.
- `out_data`  out  128  `in_data ^ keystream`. Reset value 0.
- `out_ready`  in  1  downstream accepts the result.
- `err`  out  1  sticky timeout flag. Reset value 0.
- `core_start`  out  1  drives the core's `start`. Reset value 0.
- `core_state`  out  128  current counter block, drives the core's `state`. Reset value 0.
- `core_key`  out  192  key register. Reset value 0.
- `core_out`  in  128  keystream from the core.
- `core_out_valid`  in  1  the core's `out_valid`.

## Operation
- FSM states: IDLE, PRIME, KICK, WAIT, OUT. Reset state is IDLE.
- `in_ready` is combinational: `state==IDLE && cfg_done && !cfg_load`.
- IDLE:
  - `cfg_load` loads `key`, loads `ctr`=`cfg_iv`, sets `cfg_done`=1 and clears `err`. `cfg_load` wins over a simultaneous `in_valid`.
  - Input handshake latches `in_data` into `din_q`, then → PRIME.
- PRIME: `core_start`=0 for exactly one cycle, which guarantees a 0→1 edge. → KICK.
- KICK: `core_start`=1. → WAIT.
- WAIT:
  - `core_start` stays 1.
  - When `core_out_valid`=1: register `out_data`=`din_q ^ core_out`, set `out_valid`=1, → OUT.
- OUT:
  - `core_start` drops to 0.
  - `out_valid` and `out_data` are held until `out_ready`.
  - On the output handshake: `ctr` ← `ctr+1` mod 2^128 (all-ones wraps to 0), `out_valid` ← 0, → IDLE.
- `core_state` is always `ctr`; `core_key` is always `key`. Both change only in IDLE, or at the OUT handshake for `ctr`.
- `cfg_load` outside IDLE is ignored and has no effect.
- Encryption and decryption are identical; the same `cfg_iv` must be used for both.
- Reset mid-operation: all registers return to reset values and `cfg_done`=0. Any in-flight block is lost.

## Timing
- Input accept at cycle 0.
- Cycle 1 is PRIME. Cycle 2 is KICK, with `core_start` rising at the end of cycle 1.
- `core_out_valid` is sampled only in WAIT, which starts at cycle 3 or later.
  - Any stale high on `core_out_valid` must clear during PRIME/KICK. The core contract is that `out_valid` falls within 1 cycle of `start` going low.
- Core latency L cycles, counted from the first cycle `core_start`=1 to the first cycle `core_out_valid`=1, gives `out_valid` at cycle 3+L.
  - Throughput with `out_ready` tied high: one block per L+4 cycles.
- Back-to-back blocks: after the OUT handshake, IDLE lasts at least one cycle before the next accept.

## Configuration
- `AES_CTR_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs from 0 on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `core_out_valid`: set `err`=1, drop the block (no `out_valid`, `ctr` unchanged), → IDLE.
  - `err` is cleared only by `cfg_load` or by reset.
- `AES_CTR_TIMEOUT_EN` undefined: WAIT is unbounded, `err` is tied to 0, and no counter is synthesized.

## Test plan
- Load key `000102…17`, iv `0`, then send a block of all zeros → `out_data` equals the `aes_192` encryption of 0 under that key. Feeding that result back in with the same iv returns all zeros.
- Send 3 blocks with iv=`ffff…fffe` → `core_state` goes `…fe`, `…ff`, `0`, confirming the wrap.
- Hold `out_ready`=0 for 10 cycles in OUT → `out_valid`/`out_data` are stable, `in_ready`=0, and `ctr` is unchanged until the handshake.
- Model `core_out_valid` stuck high from a prior block → `core_start` shows 0 for one cycle before every rise, and no early capture occurs.
- With `AES_CTR_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, never assert `core_out_valid` → `err`=1 after 16 WAIT cycles, no `out_valid`, and the FSM is back in IDLE. A following `cfg_load` clears `err`.
- Assert `rst_n` low during WAIT, and separately raise `cfg_load` during WAIT → reset clears all outputs and `cfg_done`. `cfg_load` in WAIT is ignored.
